// File: rtl/i2s_transmitter.sv
// I2S transmitter: accepts 24-bit stereo sample pairs over valid/ready,
// double-buffers them (holding register + per-channel shift register) and
// serialises them MSB-first onto BCLK/LRCLK/SDATA with one-BCLK data delay.
// Frames that start with nothing held transmit silence and flag an underrun.
module i2s_transmitter #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int SLOT_WIDTH   = 32,
   parameter int HALF_PERIOD  = 16
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    enable_in,
   input  logic [SAMPLE_WIDTH-1:0] sample_l_in,
   input  logic [SAMPLE_WIDTH-1:0] sample_r_in,
   input  logic                    sample_valid_in,
   output logic                    sample_ready_out,
   output logic                    i2s_bclk_out,
   output logic                    i2s_lrclk_out,
   output logic                    i2s_sdata_out,
   output logic                    frame_start_out,
   output logic                    underrun_out
);

   localparam int POS_COUNT = 2 * SLOT_WIDTH;
   localparam int POS_W     = $clog2(POS_COUNT);
   localparam int DIV_W     = $clog2(HALF_PERIOD);

   localparam logic [POS_W-1:0] LAST_POS    = POS_W'(POS_COUNT - 1);
   localparam logic [POS_W-1:0] ONE_POS     = POS_W'(1);
   localparam logic [POS_W-1:0] LEFT_LAST   = POS_W'(SAMPLE_WIDTH);
   localparam logic [POS_W-1:0] SLOT_START  = POS_W'(SLOT_WIDTH);
   localparam logic [POS_W-1:0] RIGHT_FIRST = POS_W'(SLOT_WIDTH + 1);
   localparam logic [POS_W-1:0] RIGHT_LAST  = POS_W'(SLOT_WIDTH + SAMPLE_WIDTH);
   localparam logic [DIV_W-1:0] LAST_DIV    = DIV_W'(HALF_PERIOD - 1);
   localparam logic [DIV_W-1:0] ONE_DIV     = DIV_W'(1);

   logic [DIV_W-1:0]        divCnt;
   logic [POS_W-1:0]        bitPos;
   logic [POS_W-1:0]        nextPos;
   logic                    holdValid;
   logic [SAMPLE_WIDTH-1:0] holdL;
   logic [SAMPLE_WIDTH-1:0] holdR;
   logic [SAMPLE_WIDTH-1:0] shiftL;
   logic [SAMPLE_WIDTH-1:0] shiftR;
   logic                    divWrap;
   logic                    fallEvent;
   logic                    frameBoundary;
   logic                    acceptPair;
   logic                    inLeft;
   logic                    inRight;

   assign sample_ready_out = !holdValid;

   // Decode the events of this cycle: divider wrap, BCLK falling edge, the
   // slot position it moves to, frame boundary and handshake acceptance.
   always_comb begin
      divWrap       = enable_in && (divCnt == LAST_DIV);
      fallEvent     = divWrap && i2s_bclk_out;
      nextPos       = (bitPos == LAST_POS) ? '0 : bitPos + ONE_POS;
      frameBoundary = fallEvent && (nextPos == '0);
      acceptPair    = sample_valid_in && !holdValid;
      inLeft        = (nextPos >= ONE_POS) && (nextPos <= LEFT_LAST);
      inRight       = (nextPos >= RIGHT_FIRST) && (nextPos <= RIGHT_LAST);
   end

   // BCLK generator: count HALF_PERIOD system clocks per half-period and
   // toggle; disabling parks the divider and BCLK low.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         divCnt       <= '0;
         i2s_bclk_out <= 1'b0;
      end else if (!enable_in) begin
         divCnt       <= '0;
         i2s_bclk_out <= 1'b0;
      end else if (divWrap) begin
         divCnt       <= '0;
         i2s_bclk_out <= !i2s_bclk_out;
      end else begin
         divCnt <= divCnt + ONE_DIV;
      end
   end

   // Slot position, word select and serial data all advance together on
   // the BCLK falling edge; data lags the slot start by one BCLK.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         bitPos        <= LAST_POS;
         i2s_lrclk_out <= 1'b0;
         i2s_sdata_out <= 1'b0;
      end else if (!enable_in) begin
         bitPos        <= LAST_POS;
         i2s_lrclk_out <= 1'b0;
         i2s_sdata_out <= 1'b0;
      end else if (fallEvent) begin
         bitPos        <= nextPos;
         i2s_lrclk_out <= (nextPos >= SLOT_START);
         if (inLeft) begin
            i2s_sdata_out <= shiftL[SAMPLE_WIDTH-1];
         end else if (inRight) begin
            i2s_sdata_out <= shiftR[SAMPLE_WIDTH-1];
         end else begin
            i2s_sdata_out <= 1'b0;
         end
      end
   end

   // Holding register captures accepted pairs; at each frame boundary it
   // hands its pair to the shift registers (or silence if empty), and the
   // shift registers walk out one bit per falling edge inside their slot.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         holdValid <= 1'b0;
         holdL     <= '0;
         holdR     <= '0;
         shiftL    <= '0;
         shiftR    <= '0;
      end else begin
         if (acceptPair) begin
            holdValid <= 1'b1;
            holdL     <= sample_l_in;
            holdR     <= sample_r_in;
         end
         if (frameBoundary) begin
            if (holdValid) begin
               shiftL    <= holdL;
               shiftR    <= holdR;
               holdValid <= 1'b0;
            end else begin
               shiftL <= '0;
               shiftR <= '0;
            end
         end else if (fallEvent) begin
            if (inLeft) begin
               shiftL <= {shiftL[SAMPLE_WIDTH-2:0], 1'b0};
            end
            if (inRight) begin
               shiftR <= {shiftR[SAMPLE_WIDTH-2:0], 1'b0};
            end
         end
      end
   end

   // Single-cycle status pulses aligned with the boundary's BCLK fall.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         frame_start_out <= 1'b0;
         underrun_out    <= 1'b0;
      end else begin
         frame_start_out <= frameBoundary;
         underrun_out    <= frameBoundary && !holdValid;
      end
   end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Testbench for i2s_transmitter. A cycle-count reference model derives the
// expected bus state from the number of enabled clocks since enable/reset,
// while a small scoreboard tracks held and in-flight sample pairs.
module tb_i2s_transmitter;

   localparam int SW           = 24;
   localparam int SLOT         = 32;
   localparam int HALF         = 2;
   localparam int FRAME_CYCLES = 2 * SLOT * 2 * HALF;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          enable_in;
   logic [SW-1:0] sample_l_in;
   logic [SW-1:0] sample_r_in;
   logic          sample_valid_in;
   logic          sample_ready_out;
   logic          i2s_bclk_out;
   logic          i2s_lrclk_out;
   logic          i2s_sdata_out;
   logic          frame_start_out;
   logic          underrun_out;

   int checks   = 0;
   int failures = 0;

   int            mK;
   bit            mHold;
   logic [SW-1:0] mHoldL;
   logic [SW-1:0] mHoldR;
   logic [SW-1:0] mCurL;
   logic [SW-1:0] mCurR;
   bit            mFrame;
   bit            mUnder;
   bit            mAcc;

   bit autoFeed  = 1'b0;
   bit randValid = 1'b0;
   int dutAccepts;
   int dutUnders;
   int dutFrames;
   int dutOnes;

   i2s_transmitter #(
      .SAMPLE_WIDTH(SW),
      .SLOT_WIDTH  (SLOT),
      .HALF_PERIOD (HALF)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .enable_in       (enable_in),
      .sample_l_in     (sample_l_in),
      .sample_r_in     (sample_r_in),
      .sample_valid_in (sample_valid_in),
      .sample_ready_out(sample_ready_out),
      .i2s_bclk_out    (i2s_bclk_out),
      .i2s_lrclk_out   (i2s_lrclk_out),
      .i2s_sdata_out   (i2s_sdata_out),
      .frame_start_out (frame_start_out),
      .underrun_out    (underrun_out)
   );

   // Free-running system clock.
   always #5 clk_in = ~clk_in;

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic checkInt(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int modelPos();
      return (mK / (2 * HALF) + 2 * SLOT - 1) % (2 * SLOT);
   endfunction

   task automatic checkOutput();
      logic eB;
      logic eL;
      logic eD;
      int   p;
      eB = ((mK / HALF) % 2) == 1;
      eL = 1'b0;
      eD = 1'b0;
      if (mK >= 2 * HALF) begin
         p  = modelPos();
         eL = (p >= SLOT);
         if (p >= 1 && p <= SW) eD = mCurL[SW-p];
         else if (p >= SLOT + 1 && p <= SLOT + SW) eD = mCurR[SLOT+SW-p];
      end
      checkBit("bclk", i2s_bclk_out, eB);
      checkBit("lrclk", i2s_lrclk_out, eL);
      checkBit("sdata", i2s_sdata_out, eD);
      checkBit("frameStart", frame_start_out, mFrame);
      checkBit("underrun", underrun_out, mUnder);
      checkBit("ready", sample_ready_out, !mHold);
   endtask

   task automatic resetModel();
      mK     = 0;
      mHold  = 1'b0;
      mHoldL = '0;
      mHoldR = '0;
      mCurL  = '0;
      mCurR  = '0;
      mFrame = 1'b0;
      mUnder = 1'b0;
      mAcc   = 1'b0;
   endtask

   task automatic stepModel();
      mAcc   = sample_valid_in && !mHold;
      mFrame = 1'b0;
      mUnder = 1'b0;
      if (enable_in) mK++;
      else mK = 0;
      if (enable_in && (mK % (2 * HALF)) == 0 && ((mK / (2 * HALF)) % (2 * SLOT)) == 1) begin
         mFrame = 1'b1;
         if (mHold) begin
            mCurL = mHoldL;
            mCurR = mHoldR;
            mHold = 1'b0;
         end else begin
            mCurL  = '0;
            mCurR  = '0;
            mUnder = 1'b1;
         end
      end
      if (mAcc) begin
         mHold  = 1'b1;
         mHoldL = sample_l_in;
         mHoldR = sample_r_in;
      end
   endtask

   task automatic applyStimulus(input logic en, input logic v, input logic [SW-1:0] l,
                                input logic [SW-1:0] r);
      enable_in       = en;
      sample_valid_in = v;
      sample_l_in     = l;
      sample_r_in     = r;
   endtask

   task automatic clearCounts();
      dutAccepts = 0;
      dutUnders  = 0;
      dutFrames  = 0;
      dutOnes    = 0;
   endtask

   task automatic tick();
      if (sample_valid_in && sample_ready_out) dutAccepts++;
      @(posedge clk_in);
      if (!rst_in) resetModel();
      else stepModel();
      #1;
      checkOutput();
      if (underrun_out) dutUnders++;
      if (frame_start_out) dutFrames++;
      if (i2s_sdata_out) dutOnes++;
      if (randValid) begin
         applyStimulus(enable_in, ($urandom_range(0, 4) == 0), SW'($urandom), SW'($urandom));
      end else if (autoFeed && mAcc) begin
         applyStimulus(enable_in, 1'b1, SW'($urandom), SW'($urandom));
      end
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic runUntilBoundary(input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         tick();
         seen = mFrame;
      end
      if (!seen) checkBit("boundaryTimeout", 1'b0, 1'b1);
   endtask

   task automatic runUntilAccepted(input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         tick();
         seen = mAcc;
      end
      if (!seen) checkBit("acceptTimeout", 1'b0, 1'b1);
   endtask

   task automatic runUntilPos(input int target, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         tick();
         seen = (mK >= 2 * HALF) && (mK % (2 * HALF) == 0) && (modelPos() == target);
      end
      if (!seen) checkBit("positionTimeout", 1'b0, 1'b1);
   endtask

   task automatic waitFrameStart(input int limit, output int n);
      n = -1;
      for (int i = 0; i < limit && n < 0; i++) begin
         tick();
         if (frame_start_out) n = i + 1;
      end
   endtask

   // Directed sequence covering reset, known patterns, underrun, streaming,
   // sign-bit padding, enable drop, mid-frame reset and a random phase.
   initial begin
      int n;
      resetModel();
      clearCounts();
      rst_in = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0);
      #1;
      checkOutput();
      runCycles(3);
      rst_in = 1'b1;
      runCycles(2);

      $display("[TB] known pattern A5A5A5 / 5A5A5A");
      applyStimulus(1'b0, 1'b1, 24'hA5A5A5, 24'h5A5A5A);
      runUntilAccepted(4);
      applyStimulus(1'b1, 1'b0, '0, '0);
      runCycles(2 * FRAME_CYCLES + 50);

      $display("[TB] no samples supplied");
      clearCounts();
      runCycles(3 * FRAME_CYCLES);
      checkInt("idleUnderruns", dutUnders, 3);
      checkInt("idleFrames", dutFrames, 3);
      checkInt("idleDataOnes", dutOnes, 0);

      $display("[TB] back-to-back streaming");
      autoFeed = 1'b1;
      applyStimulus(1'b1, 1'b1, SW'($urandom), SW'($urandom));
      runUntilBoundary(FRAME_CYCLES + 10);
      runUntilBoundary(FRAME_CYCLES + 10);
      clearCounts();
      runCycles(8 * FRAME_CYCLES);
      checkInt("streamAccepts", dutAccepts, 8);
      checkInt("streamUnderruns", dutUnders, 0);
      checkInt("streamFrames", dutFrames, 8);
      autoFeed = 1'b0;
      applyStimulus(1'b1, 1'b0, '0, '0);

      $display("[TB] extreme values 800000 / 7FFFFF");
      runUntilBoundary(FRAME_CYCLES + 10);
      applyStimulus(1'b1, 1'b1, 24'h800000, 24'h7FFFFF);
      runUntilAccepted(10);
      applyStimulus(1'b1, 1'b0, '0, '0);
      runCycles(2 * FRAME_CYCLES);

      $display("[TB] enable dropped mid right slot");
      runUntilBoundary(FRAME_CYCLES + 10);
      applyStimulus(1'b1, 1'b1, SW'($urandom), SW'($urandom));
      runUntilAccepted(10);
      applyStimulus(1'b1, 1'b0, '0, '0);
      runUntilPos(40, FRAME_CYCLES + 10);
      applyStimulus(1'b0, 1'b0, '0, '0);
      runCycles(1);
      checkBit("disableBclk", i2s_bclk_out, 1'b0);
      checkBit("disableLrclk", i2s_lrclk_out, 1'b0);
      checkBit("disableHeld", sample_ready_out, 1'b0);
      runCycles(9);
      applyStimulus(1'b1, 1'b0, '0, '0);
      waitFrameStart(20, n);
      checkInt("reenableLatency", n, 4);
      checkBit("reenableNoUnderrun", underrun_out, 1'b0);
      runCycles(FRAME_CYCLES);

      $display("[TB] reset mid-frame with a held pair");
      runUntilBoundary(FRAME_CYCLES + 10);
      applyStimulus(1'b1, 1'b1, SW'($urandom), SW'($urandom));
      runUntilAccepted(10);
      applyStimulus(1'b1, 1'b0, '0, '0);
      runUntilPos(10, FRAME_CYCLES + 10);
      #2;
      rst_in = 1'b0;
      #1;
      resetModel();
      checkOutput();
      checkBit("resetReady", sample_ready_out, 1'b1);
      runCycles(2);
      rst_in = 1'b1;
      waitFrameStart(20, n);
      checkInt("resetFirstBoundary", n, 4);
      checkBit("resetFirstUnderrun", underrun_out, 1'b1);

      $display("[TB] random traffic");
      randValid = 1'b1;
      runCycles(4 * FRAME_CYCLES);
      randValid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
